i2c_slave_resp: RTL and testbench



---
 rtl/i2c_slave_resp_pkg.sv | 21 ++
 rtl/i2c_slave_resp_if.sv | 24 ++
 rtl/i2c_slave_resp_bus_sync.sv | 45 ++++
 rtl/i2c_slave_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_slave_resp.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_resp_pkg.sv
// Shared types and constants for the I2C responder: FSM state encoding,
// the R/W bit values, and the ACK/NACK line levels.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_resp_state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_slave_resp_if.sv
// Bus-side bundle of the I2C responder: the wired SCL/SDA view, the open-drain
// SDA drive, and the write-event stream used for scoreboarding.
interface i2c_slave_resp_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
);
  logic              scl_i;
  logic              sda_i;
  logic              sda_o;
  logic              busy;
  logic              wr_valid;
  logic [PTR_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, busy, wr_valid, wr_addr, wr_data
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, busy, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_slave_resp_bus_sync.sv
// Two-flop synchronizer for SCL/SDA plus one history stage, producing SCL edge
// strobes and START/STOP detection in the clk_i domain.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastability flop, [1] synchronized value, [2] previous synchronized value.
  // Reset to the idle-high bus level so no edges are fabricated out of reset.
  logic [2:0] r_sclPipe;
  logic [2:0] r_sdaPipe;
  logic       w_sclNow;
  logic       w_sclPrev;
  logic       w_sdaNow;
  logic       w_sdaPrev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclPipe <= 3'b111;
      r_sdaPipe <= 3'b111;
    end else begin
      r_sclPipe <= {r_sclPipe[1:0], scl_i};
      r_sdaPipe <= {r_sdaPipe[1:0], sda_i};
    end
  end

  assign w_sclNow  = r_sclPipe[1];
  assign w_sclPrev = r_sclPipe[2];
  assign w_sdaNow  = r_sdaPipe[1];
  assign w_sdaPrev = r_sdaPipe[2];

  assign scl_rise  = w_sclNow & ~w_sclPrev;
  assign scl_fall  = ~w_sclNow & w_sclPrev;
  assign start_det = w_sclNow & w_sclPrev & ~w_sdaNow & w_sdaPrev;
  assign stop_det  = w_sclNow & w_sclPrev & w_sdaNow & ~w_sdaPrev;
  assign sda_s     = w_sdaNow;

endmodule

// File: rtl/i2c_slave_resp.sv
// I2C responder at a fixed 7-bit address serving a small byte memory through
// a persistent register pointer; every stored byte is reported on wr_*.
module i2c_slave_resp
  import i2c_resp_pkg::*;
#(
  parameter int          I2C_ADDR_WIDTH = 7,
  parameter int          I2C_DATA_WIDTH = 8,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
  parameter int          MEM_DEPTH      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  i2c_slave_resp_if.slave   bus
);

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int DW    = I2C_DATA_WIDTH;

  i2c_resp_state_t r_state, w_stateNext;
  logic [3:0]       r_bitCnt, w_bitCntNext;
  logic [DW-1:0]    r_shift, w_shiftNext;
  logic             r_sdaO, w_sdaONext;
  logic [PTR_W-1:0] r_ptr, w_ptrNext;
  logic             r_firstByte, w_firstNext;
  logic             r_busy, w_busyNext;
  logic             r_rw, w_rwNext;
  logic             r_mstAck, w_mstAckNext;
  logic             w_memWe;
  logic [DW-1:0]    w_wrByte;
  logic [DW-1:0]    r_mem [MEM_DEPTH];
  logic             r_wrValid;
  logic [PTR_W-1:0] r_wrAddr;
  logic [DW-1:0]    r_wrData;

  logic w_sclRise, w_sclFall, w_startDet, w_stopDet, w_sdaS;

  i2c_bus_sync u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (w_sclRise),
    .scl_fall  (w_sclFall),
    .start_det (w_startDet),
    .stop_det  (w_stopDet),
    .sda_s     (w_sdaS)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_sdaO      <= 1'b1;
      r_ptr       <= '0;
      r_firstByte <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= I2C_WRITE;
      r_mstAck    <= I2C_NACK;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_sdaO      <= w_sdaONext;
      r_ptr       <= w_ptrNext;
      r_firstByte <= w_firstNext;
      r_busy      <= w_busyNext;
      r_rw        <= w_rwNext;
      r_mstAck    <= w_mstAckNext;
    end
  end

  // sda_o only moves on a detected SCL fall, so the master always sees stable
  // data while SCL is high; START/STOP override everything and release the line.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_sdaONext   = r_sdaO;
    w_ptrNext    = r_ptr;
    w_firstNext  = r_firstByte;
    w_busyNext   = r_busy;
    w_rwNext     = r_rw;
    w_mstAckNext = r_mstAck;
    w_memWe      = 1'b0;
    w_wrByte     = {r_shift[DW-2:0], w_sdaS};

    if (w_startDet) begin
      w_stateNext  = ST_ADDR;
      w_bitCntNext = '0;
      w_sdaONext   = I2C_NACK;
      w_busyNext   = 1'b0;
    end else if (w_stopDet) begin
      w_stateNext  = ST_IDLE;
      w_bitCntNext = '0;
      w_sdaONext   = I2C_NACK;
      w_busyNext   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_sclRise) begin
            w_shiftNext  = w_wrByte;
            w_bitCntNext = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            w_bitCntNext = '0;
            if (r_shift[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
              w_stateNext = ST_ADDR_ACK;
              w_sdaONext  = I2C_ACK;
              w_busyNext  = 1'b1;
              w_rwNext    = r_shift[0];
            end else begin
              w_stateNext = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_sclFall) begin
            w_bitCntNext = '0;
            if (r_rw == I2C_WRITE) begin
              w_stateNext = ST_WR_BYTE;
              w_sdaONext  = I2C_NACK;
              w_firstNext = 1'b1;
            end else begin
              w_stateNext = ST_RD_BYTE;
              w_shiftNext = r_mem[r_ptr];
              w_sdaONext  = r_mem[r_ptr][DW-1];
            end
          end
        end
        ST_WR_BYTE: begin
          if (w_sclRise) begin
            w_shiftNext  = w_wrByte;
            w_bitCntNext = r_bitCnt + 4'd1;
            if (r_bitCnt == 4'd7) begin
              if (r_firstByte) begin
                w_ptrNext   = w_wrByte[PTR_W-1:0];
                w_firstNext = 1'b0;
              end else begin
                w_memWe   = 1'b1;
                w_ptrNext = r_ptr + PTR_W'(1);
              end
            end
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            w_stateNext  = ST_WR_ACK;
            w_sdaONext   = I2C_ACK;
            w_bitCntNext = '0;
          end
        end
        ST_WR_ACK: begin
          if (w_sclFall) begin
            w_stateNext = ST_WR_BYTE;
            w_sdaONext  = I2C_NACK;
          end
        end
        ST_RD_BYTE: begin
          if (w_sclRise) begin
            w_bitCntNext = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            w_stateNext  = ST_RD_ACK;
            w_sdaONext   = I2C_NACK;
            w_ptrNext    = r_ptr + PTR_W'(1);
            w_bitCntNext = '0;
          end else if (w_sclFall && r_bitCnt != 4'd0) begin
            w_shiftNext = {r_shift[DW-2:0], 1'b0};
            w_sdaONext  = r_shift[DW-2];
          end
        end
        ST_RD_ACK: begin
          if (w_sclRise) begin
            w_mstAckNext = w_sdaS;
            w_bitCntNext = 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd1) begin
            w_bitCntNext = '0;
            if (r_mstAck == I2C_ACK) begin
              w_stateNext = ST_RD_BYTE;
              w_shiftNext = r_mem[r_ptr];
              w_sdaONext  = r_mem[r_ptr][DW-1];
            end else begin
              w_stateNext = ST_IGNORE;
            end
          end
        end
        ST_IDLE, ST_IGNORE: begin
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_memWe) begin
      r_mem[r_ptr] <= w_wrByte;
    end
  end

  // Event outputs hold the last stored byte until the next pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
    end else begin
      r_wrValid <= w_memWe;
      if (w_memWe) begin
        r_wrAddr <= r_ptr;
        r_wrData <= w_wrByte;
      end
    end
  end

  assign bus.sda_o    = r_sdaO;
  assign bus.busy     = r_busy;
  assign bus.wr_valid = r_wrValid;
  assign bus.wr_addr  = r_wrAddr;
  assign bus.wr_data  = r_wrData;

endmodule

// File: tb/tb_i2c_slave_resp.sv
// Directed bench for i2c_slave_resp: bit-banged I2C master on a wired-AND SDA
// line, write events captured off wr_valid and compared to hand-computed bytes.
module tb_i2c_slave_resp;

  logic clk;
  logic rst;
  logic sclM;
  logic sdaM;
  logic ackBit;
  logic [7:0] rdByte;
  logic [11:0] evQ [$];
  int compareCount;
  int mismatchCount;

  i2c_slave_resp_if busIf ();

  assign busIf.scl_i = sclM;
  assign busIf.sda_i = sdaM & busIf.sda_o;

  i2c_slave_resp dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every stored byte is recorded as {addr, data} for later comparison.
  always @(negedge clk) begin
    if (busIf.wr_valid) evQ.push_back({busIf.wr_addr, busIf.wr_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic scl, input logic sda);
    sclM = scl;
    sdaM = sda;
    repeat (5) @(negedge clk);
  endtask

  task automatic sendStart();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendRepStart();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendStop();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, b);
    applyStimulus(1'b1, b);
    applyStimulus(1'b1, b);
    applyStimulus(1'b0, b);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    b = busIf.sda_i;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic writeByte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] data);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      data[i] = b;
    end
    writeBit(masterAck);
  endtask

  function automatic logic [11:0] getEv(input int idx);
    if (evQ.size() > idx) return evQ[idx];
    return 12'hFFF;
  endfunction

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    sclM = 1'b1;
    sdaM = 1'b1;
    rst  = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_sda_o", busIf.sda_o, 1);
    checkOutput("rst_busy", busIf.busy, 0);
    checkOutput("rst_wr_valid", busIf.wr_valid, 0);
    checkOutput("rst_wr_addr", busIf.wr_addr, 0);
    checkOutput("rst_wr_data", busIf.wr_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] write ptr=3, data A5 5A");
    evQ.delete();
    sendStart();
    writeByte(8'h44, ackBit); checkOutput("wr_addr_ack", ackBit, 0);
    checkOutput("wr_busy_high", busIf.busy, 1);
    writeByte(8'h03, ackBit); checkOutput("wr_ptr_ack", ackBit, 0);
    writeByte(8'hA5, ackBit); checkOutput("wr_d0_ack", ackBit, 0);
    writeByte(8'h5A, ackBit); checkOutput("wr_d1_ack", ackBit, 0);
    sendStop();
    checkOutput("wr_ev_count", evQ.size(), 2);
    checkOutput("wr_ev0", getEv(0), {4'd3, 8'hA5});
    checkOutput("wr_ev1", getEv(1), {4'd4, 8'h5A});
    checkOutput("wr_busy_after_stop", busIf.busy, 0);

    $display("[TB] write ptr, repeated START, read two bytes");
    sendStart();
    writeByte(8'h44, ackBit); checkOutput("rd_waddr_ack", ackBit, 0);
    writeByte(8'h03, ackBit); checkOutput("rd_ptr_ack", ackBit, 0);
    sendRepStart();
    writeByte(8'h45, ackBit); checkOutput("rd_raddr_ack", ackBit, 0);
    readByte(1'b0, rdByte);   checkOutput("rd_byte0", rdByte, 8'hA5);
    readByte(1'b1, rdByte);   checkOutput("rd_byte1", rdByte, 8'h5A);
    checkOutput("rd_sda_released", busIf.sda_o, 1);
    sendStop();
    checkOutput("rd_busy_after_stop", busIf.busy, 0);

    $display("[TB] wrong address 0x23");
    evQ.delete();
    sendStart();
    writeByte(8'h46, ackBit); checkOutput("bad_addr_nack", ackBit, 1);
    checkOutput("bad_addr_busy", busIf.busy, 0);
    writeByte(8'h03, ackBit); checkOutput("bad_data_nack", ackBit, 1);
    writeByte(8'hFF, ackBit);
    sendStop();
    checkOutput("bad_ev_count", evQ.size(), 0);
    sendStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h03, ackBit);
    sendRepStart();
    writeByte(8'h45, ackBit);
    readByte(1'b1, rdByte); checkOutput("bad_mem_unchanged", rdByte, 8'hA5);
    sendStop();

    $display("[TB] pointer wrap");
    evQ.delete();
    sendStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h0F, ackBit);
    writeByte(8'h11, ackBit); checkOutput("wrap_d0_ack", ackBit, 0);
    writeByte(8'h22, ackBit); checkOutput("wrap_d1_ack", ackBit, 0);
    sendStop();
    checkOutput("wrap_ev_count", evQ.size(), 2);
    checkOutput("wrap_ev0", getEv(0), {4'd15, 8'h11});
    checkOutput("wrap_ev1", getEv(1), {4'd0, 8'h22});
    sendStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h0F, ackBit);
    sendRepStart();
    writeByte(8'h45, ackBit);
    readByte(1'b0, rdByte); checkOutput("wrap_rd15", rdByte, 8'h11);
    readByte(1'b1, rdByte); checkOutput("wrap_rd0", rdByte, 8'h22);
    sendStop();

    $display("[TB] reset during 5th data bit of a read");
    evQ.delete();
    sendStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h03, ackBit);
    sendRepStart();
    writeByte(8'h45, ackBit);
    for (int i = 0; i < 4; i++) readBit(ackBit);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rd_bit5_driven", busIf.sda_o, 0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_sda_release", busIf.sda_o, 1);
    checkOutput("mid_rst_busy", busIf.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    sendStop();
    sendStart();
    writeByte(8'h44, ackBit); checkOutput("post_rst_addr_ack", ackBit, 0);
    writeByte(8'h02, ackBit);
    writeByte(8'h77, ackBit); checkOutput("post_rst_data_ack", ackBit, 0);
    sendRepStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h02, ackBit);
    sendRepStart();
    writeByte(8'h45, ackBit);
    readByte(1'b0, rdByte); checkOutput("post_rst_rd2", rdByte, 8'h77);
    readByte(1'b1, rdByte); checkOutput("post_rst_mem3_cleared", rdByte, 8'h00);
    sendStop();
    checkOutput("post_rst_ev_count", evQ.size(), 1);
    checkOutput("post_rst_ev0", getEv(0), {4'd2, 8'h77});

    $display("[TB] STOP in the middle of a write byte");
    evQ.delete();
    sendStart();
    writeByte(8'h44, ackBit);
    writeByte(8'h05, ackBit); checkOutput("stop_ptr_ack", ackBit, 0);
    writeBit(1'b1);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b0);
    sendStop();
    checkOutput("stop_ev_count", evQ.size(), 0);
    checkOutput("stop_busy", busIf.busy, 0);
    checkOutput("stop_wr_valid", busIf.wr_valid, 0);
    sendStart();
    writeByte(8'h45, ackBit); checkOutput("stop_next_addr_ack", ackBit, 0);
    readByte(1'b1, rdByte);   checkOutput("stop_mem5_untouched", rdByte, 8'h00);
    sendStop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
